regfile_sb: RTL and testbench

- Parametrised next-generation general register file for the pipelined datapath.
- Provides two combinational read ports and one write port, with optional register 0 hardwired to zero and an optional write-to-read bypass.
- Includes a per-register pending scoreboard with an outstanding-writer counter, so decode can detect RAW hazards without external tracking.
- Sits between decode (read, issue) and writeback.

---
 rtl/regfile_sb.sv | 171 +++++++++++++++++
 tb/tb_regfile_sb.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_sb.sv
// ---------------------------------------------------------------------------
// regfile_sb -- general register file with a RAW-hazard scoreboard.
//
// Two combinational read ports, one write port, and a per-register "pending"
// bit that decode sets at issue and writeback clears at write.
// PendCount is a registered count of the pending bits.
//
// Parameters
//   DATA_WIDTH  bits per register
//   ADDR_WIDTH  register index width, depth = 2**ADDR_WIDTH
//   ZERO_REG    1: register 0 reads 0, ignores writes, is never pending
//   BYPASS      1: this cycle's write data is forwarded to matching reads
//
// Ports
//   clock, resetn          rising-edge clock, asynchronous active-low reset
//   Readreg1/2             read addresses
//   Readdata1/2            read data (combinational)
//   RegWrite               write enable
//   Writereg, Writedata    write address and data
//   Issue, Issuereg        mark Issuereg as having an outstanding writer
//   Busy1/2                read address has an outstanding writer that is
//                          not satisfied by forwarding this cycle
//   PendCount              number of registers currently pending
//
// Handshake: there is no flow control. Every command is accepted on the
// rising edge where its enable (RegWrite / Issue) is high. Reads and Busy
// flags are pure functions of the current state and inputs.
// ---------------------------------------------------------------------------
module regfile_sb #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5,
  parameter int ZERO_REG   = 1,
  parameter int BYPASS     = 1
) (
  input  logic                  clock,
  input  logic                  resetn,
  input  logic [ADDR_WIDTH-1:0] Readreg1,
  input  logic [ADDR_WIDTH-1:0] Readreg2,
  output logic [DATA_WIDTH-1:0] Readdata1,
  output logic [DATA_WIDTH-1:0] Readdata2,
  input  logic                  RegWrite,
  input  logic [ADDR_WIDTH-1:0] Writereg,
  input  logic [DATA_WIDTH-1:0] Writedata,
  input  logic                  Issue,
  input  logic [ADDR_WIDTH-1:0] Issuereg,
  output logic                  Busy1,
  output logic                  Busy2,
  output logic [ADDR_WIDTH:0]   PendCount
);

  localparam int DEPTH = 1 << ADDR_WIDTH;

  localparam logic ZERO_EN   = (ZERO_REG != 0);
  localparam logic BYPASS_EN = (BYPASS != 0);

  logic [DATA_WIDTH-1:0] gr [DEPTH];
  logic [DEPTH-1:0]      pend;
  logic [DEPTH-1:0]      pend_next;
  logic [ADDR_WIDTH:0]   pend_count;
  logic [ADDR_WIDTH:0]   pend_count_next;

  // Index 0 is a sink when ZERO_REG is set: writes and issues to it vanish.
  logic write_zero;
  logic issue_zero;
  logic wr_en;
  logic issue_en;

  assign write_zero = ZERO_EN && (Writereg == '0);
  assign issue_zero = ZERO_EN && (Issuereg == '0);
  assign wr_en      = RegWrite && !write_zero;
  assign issue_en   = Issue && !issue_zero;

  // -------------------------------------------------------------------------
  // Register array
  // -------------------------------------------------------------------------
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      for (int i = 0; i < DEPTH; i++) begin
        gr[i] <= '0;
      end
    end else if (wr_en) begin
      gr[Writereg] <= Writedata;
    end
  end

  // -------------------------------------------------------------------------
  // Scoreboard
  // -------------------------------------------------------------------------
  // Clear first, then set: when issue and write hit the same register on the
  // same edge the new producer wins and the register stays pending.
  always_comb begin
    pend_next = pend;
    if (RegWrite) begin
      pend_next[Writereg] = 1'b0;
    end
    if (issue_en) begin
      pend_next[Issuereg] = 1'b1;
    end
  end

  // The counter tracks transitions of pend rather than recounting it:
  // +1 only when a clear bit becomes set, -1 only when a set bit becomes
  // clear and is not re-set on the same edge.
  logic set_new;
  logic clr_old;

  assign set_new = issue_en && !pend[Issuereg];
  assign clr_old = RegWrite && pend[Writereg] &&
                   !(issue_en && (Issuereg == Writereg));

  always_comb begin
    pend_count_next = pend_count;
    if (set_new && !clr_old) begin
      pend_count_next = pend_count + 1'b1;
    end else if (clr_old && !set_new) begin
      pend_count_next = pend_count - 1'b1;
    end
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      pend       <= '0;
      pend_count <= '0;
    end else begin
      pend       <= pend_next;
      pend_count <= pend_count_next;
    end
  end

  assign PendCount = pend_count;

  // -------------------------------------------------------------------------
  // Read ports
  // -------------------------------------------------------------------------
  logic fwd1;
  logic fwd2;
  logic zero1;
  logic zero2;

  assign fwd1  = BYPASS_EN && RegWrite && (Writereg == Readreg1);
  assign fwd2  = BYPASS_EN && RegWrite && (Writereg == Readreg2);
  assign zero1 = ZERO_EN && (Readreg1 == '0);
  assign zero2 = ZERO_EN && (Readreg2 == '0);

  // Reset masks the outputs so the forwarding path cannot leak write data
  // while the array is being held clear.
  always_comb begin
    Readdata1 = gr[Readreg1];
    if (fwd1) begin
      Readdata1 = Writedata;
    end
    if (zero1 || !resetn) begin
      Readdata1 = '0;
    end
  end

  always_comb begin
    Readdata2 = gr[Readreg2];
    if (fwd2) begin
      Readdata2 = Writedata;
    end
    if (zero2 || !resetn) begin
      Readdata2 = '0;
    end
  end

  // Forwarded data satisfies the hazard, so a matching write hides Busy.
  assign Busy1 = resetn && pend[Readreg1] && !fwd1 && !zero1;
  assign Busy2 = resetn && pend[Readreg2] && !fwd2 && !zero2;

endmodule

// File: tb/tb_regfile_sb.sv
// ---------------------------------------------------------------------------
// tb_regfile_sb -- directed bench for regfile_sb.
// Two instances share all inputs: dut_b (BYPASS=1) and dut_n (BYPASS=0).
// Inputs change 1 time unit after a rising edge; combinational outputs are
// sampled 1 unit later, well away from the next edge.
// ---------------------------------------------------------------------------
module tb_regfile_sb;

  logic        clock;
  logic        resetn;
  logic [4:0]  Readreg1, Readreg2, Writereg, Issuereg;
  logic        RegWrite, Issue;
  logic [31:0] Writedata;

  logic [31:0] rd1_b, rd2_b, rd1_n, rd2_n;
  logic        busy1_b, busy2_b, busy1_n, busy2_n;
  logic [5:0]  cnt_b, cnt_n;

  int n_tests = 0;
  int n_fail  = 0;

  regfile_sb #(.BYPASS(1)) dut_b (
    .clock(clock), .resetn(resetn),
    .Readreg1(Readreg1), .Readreg2(Readreg2),
    .Readdata1(rd1_b), .Readdata2(rd2_b),
    .RegWrite(RegWrite), .Writereg(Writereg), .Writedata(Writedata),
    .Issue(Issue), .Issuereg(Issuereg),
    .Busy1(busy1_b), .Busy2(busy2_b), .PendCount(cnt_b)
  );

  regfile_sb #(.BYPASS(0)) dut_n (
    .clock(clock), .resetn(resetn),
    .Readreg1(Readreg1), .Readreg2(Readreg2),
    .Readdata1(rd1_n), .Readdata2(rd2_n),
    .RegWrite(RegWrite), .Writereg(Writereg), .Writedata(Writedata),
    .Issue(Issue), .Issuereg(Issuereg),
    .Busy1(busy1_n), .Busy2(busy2_n), .PendCount(cnt_n)
  );

  // clock / reset
  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic idle();
    RegWrite  = 1'b0;
    Issue     = 1'b0;
    Writereg  = '0;
    Issuereg  = '0;
    Writedata = '0;
  endtask

  task automatic check_cnt(input string tag, input int exp);
    check({tag, "_cnt_b"}, {26'd0, cnt_b}, exp);
    check({tag, "_cnt_n"}, {26'd0, cnt_n}, exp);
  endtask

  initial begin
    resetn   = 1'b0;
    Readreg1 = '0;
    Readreg2 = '0;
    idle();

    // During reset a write with matching read must not forward.
    #12;
    RegWrite = 1'b1; Writereg = 5'd5; Writedata = 32'hDEADBEEF; Readreg1 = 5'd5;
    #1;
    check("rst_bypass_masked", rd1_b, 32'h0);
    tick();
    idle();
    #1;
    check("rst_no_write", rd1_b, 32'h0);
    resetn = 1'b1;

    // Every index reads zero, not busy, count zero.
    for (int i = 0; i < 32; i++) begin
      Readreg1 = 5'(i);
      Readreg2 = 5'(31 - i);
      #1;
      check($sformatf("rst_rd1_%0d", i), rd1_b, 32'h0);
      check($sformatf("rst_rd2_%0d", i), rd2_n, 32'h0);
      check($sformatf("rst_busy_%0d", i), {30'd0, busy1_b, busy2_b}, 32'h0);
    end
    check_cnt("rst", 0);

    // Write r5, then reset mid-cycle: r5 reads 0 immediately.
    tick();
    RegWrite = 1'b1; Writereg = 5'd5; Writedata = 32'hDEADBEEF;
    tick();
    idle();
    Readreg1 = 5'd5;
    #1;
    check("r5_written", rd1_n, 32'hDEADBEEF);
    #1;
    resetn = 1'b0;
    #1;
    check("r5_async_rst_b", rd1_b, 32'h0);
    check("r5_async_rst_n", rd1_n, 32'h0);
    tick();
    resetn = 1'b1;
    #1;
    check("r5_cleared_after_rst", rd1_n, 32'h0);

    // Write r3: bypass instance sees new data this cycle, other sees old.
    RegWrite = 1'b1; Writereg = 5'd3; Writedata = 32'h12345678; Readreg1 = 5'd3;
    #1;
    check("r3_bypass", rd1_b, 32'h12345678);
    check("r3_nobypass_old", rd1_n, 32'h0);
    tick();
    idle();
    #1;
    check("r3_b_next", rd1_b, 32'h12345678);
    check("r3_n_next", rd1_n, 32'h12345678);

    // Register 0 is hardwired.
    RegWrite = 1'b1; Writereg = 5'd0; Writedata = 32'hFFFFFFFF;
    Readreg1 = 5'd0; Readreg2 = 5'd0;
    #1;
    check("r0_bypass_blocked", rd1_b, 32'h0);
    tick();
    idle();
    #1;
    check("r0_after_write", rd2_n, 32'h0);
    Issue = 1'b1; Issuereg = 5'd0;
    tick();
    idle();
    #1;
    check("r0_busy", {31'd0, busy1_b}, 32'h0);
    check_cnt("r0_issue", 0);

    // Issue r7, r9, r7 -> 1, 2, 2.
    Issue = 1'b1; Issuereg = 5'd7;
    tick();
    #1;
    check_cnt("iss_r7", 1);
    Issuereg = 5'd9;
    tick();
    #1;
    check_cnt("iss_r9", 2);
    Issuereg = 5'd7;
    tick();
    idle();
    Readreg1 = 5'd7; Readreg2 = 5'd9;
    #1;
    check_cnt("iss_r7_again", 2);
    check("busy1_r7_b", {31'd0, busy1_b}, 32'h1);
    check("busy2_r9_n", {31'd0, busy2_n}, 32'h1);
    RegWrite = 1'b1; Writereg = 5'd7; Writedata = 32'h00000077;
    #1;
    check("busy1_r7_fwd_b", {31'd0, busy1_b}, 32'h0);
    check("busy1_r7_nofwd_n", {31'd0, busy1_n}, 32'h1);
    check("rd1_r7_fwd_b", rd1_b, 32'h00000077);
    tick();
    idle();
    #1;
    check_cnt("wr_r7", 1);
    check("busy1_r7_clear_n", {31'd0, busy1_n}, 32'h0);
    check("rd1_r7_n", rd1_n, 32'h00000077);

    // Same edge, same index: set wins, data still written.
    Issue = 1'b1; Issuereg = 5'd4;
    tick();
    #1;
    check_cnt("iss_r4", 2);
    RegWrite = 1'b1; Writereg = 5'd4; Writedata = 32'hA5A5A5A5;
    tick();
    idle();
    Readreg1 = 5'd4;
    #1;
    check_cnt("same_idx", 2);
    check("r4_still_busy", {31'd0, busy1_b}, 32'h1);
    check("r4_data", rd1_b, 32'hA5A5A5A5);

    // Same edge, different indices: both apply.
    Issue = 1'b1; Issuereg = 5'd11;
    tick();
    #1;
    check_cnt("iss_r11", 3);
    Issuereg = 5'd10;
    RegWrite = 1'b1; Writereg = 5'd11; Writedata = 32'h00001111;
    tick();
    idle();
    Readreg1 = 5'd10; Readreg2 = 5'd11;
    #1;
    check_cnt("diff_idx", 3);
    check("r10_busy", {31'd0, busy1_n}, 32'h1);
    check("r11_free", {31'd0, busy2_n}, 32'h0);
    check("r11_data", rd2_n, 32'h00001111);

    // Write to a non-pending register leaves the count alone.
    RegWrite = 1'b1; Writereg = 5'd3; Writedata = 32'h0BADF00D;
    tick();
    idle();
    Readreg1 = 5'd3;
    #1;
    check_cnt("wr_nonpend", 3);
    check("r3_overwrite", rd1_n, 32'h0BADF00D);

    // Drain remaining pending registers: r9, r4, r10.
    RegWrite = 1'b1; Writereg = 5'd9; Writedata = 32'h9;
    tick();
    #1;
    check_cnt("drain_r9", 2);
    Writereg = 5'd4; Writedata = 32'h4;
    tick();
    #1;
    check_cnt("drain_r4", 1);
    Writereg = 5'd10; Writedata = 32'hA;
    tick();
    idle();
    Readreg1 = 5'd10; Readreg2 = 5'd4;
    #1;
    check_cnt("drain_r10", 0);
    check("r10_not_busy", {30'd0, busy1_b, busy2_b}, 32'h0);
    check("r4_final", rd2_b, 32'h4);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
